hazard_stall_ctrl: RTL and testbench
====================================

# hazard_stall_ctrl

Pipeline hazard controller for the 5-stage MIPS core. It sits beside the forwarding unit and handles the hazards forwarding cannot cover. It stalls IF/ID on load-use dependences, issues and tracks the multi-cycle multiply/divide unit, holds HI/LO consumers until that unit finishes, and flushes the front of the pipe on taken branches. It also keeps a saturating count of stall cycles for performance monitoring.

## Interface
Parameters:
- MD_LATENCY, 8, cycles the mult/div unit is busy after issue (legal range ≥1)
- STALL_CNT_W, 16, width of the stall-cycle counter

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_uses_rt  in  1  instruction in ID reads rt as a source
- id_is_md  in  1  instruction in ID is MULT/MULTU/DIV/DIVU
- id_reads_hilo  in  1  instruction in ID is MFHI/MFLO
- id_ex_mem_read  in  1  instruction in EX is a load
- id_ex_rt  in  5  destination of the load in EX
- ex_branch_taken  in  1  branch/jump in EX resolved taken
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID register enable
- id_ex_bubble  out  1  zero the control bits entering ID/EX
- if_id_flush  out  1  clear IF/ID
- md_start  out  1  one-cycle issue pulse to the mult/div unit
- md_busy  out  1  registered, mult/div unit in progress
- stall_cycles  out  STALL_CNT_W  registered saturating stall counter

## Operation
- FSM states: RUN and MD_BUSY. A down-counter md_cnt has width clog2(MD_LATENCY+1).
- Definitions:
  - load_use = id_ex_mem_read & (id_ex_rt≠0) & ((id_ex_rt==id_rs) | (id_uses_rt & id_ex_rt==id_rt))
  - md_hold = md_busy & (id_is_md | id_reads_hilo)
- Priority per cycle (highest first):
  1. ex_branch_taken: if_id_flush=1, id_ex_bubble=1, pc_write=1, if_id_write=1, md_start=0.
  2. load_use: pc_write=0, if_id_write=0, id_ex_bubble=1, md_start=0.
  3. md_hold: pc_write=0, if_id_write=0, id_ex_bubble=1, md_start=0.
  4. id_is_md & !md_busy: md_start=1, normal advance.
  5. Otherwise: pc_write=1, if_id_write=1, all others 0.
- The control outputs pc_write, if_id_write, id_ex_bubble, if_id_flush and md_start are combinational from inputs and registered state (Mealy).
- RUN→MD_BUSY on an edge with md_start=1; md_cnt loads MD_LATENCY.
- In MD_BUSY, md_cnt decrements by 1 each edge. At md_cnt==1 the next edge sets md_cnt to 0 and returns the FSM to RUN.
- md_busy = (state==MD_BUSY). It is high for exactly MD_LATENCY cycles after the md_start cycle.
- A taken branch during MD_BUSY does not cancel the count, because the issued op is older than the branch.
- Non-HI/LO instructions proceed freely during MD_BUSY.
- stall_cycles increments on every edge where priority 2 or 3 applied. It holds at all-ones (saturates) and never wraps. Flush cycles are not counted.
- While reset is asserted: pc_write=0, if_id_write=0, and all other outputs 0.

## Timing
- Reset values: state=RUN, md_cnt=0, md_busy=0, stall_cycles=0.
- After reset deasserts, with all inputs low, control outputs are pc_write=1, if_id_write=1, others 0.
- Load-use costs exactly 1 bubble. The next cycle the load has moved to MEM, load_use drops, and forwarding covers the dependence.
- MFHI at ID in the cycle immediately after md_start stalls for MD_LATENCY cycles. It advances in the first cycle md_busy=0.
- A back-to-back MULT behaves the same way: the second MULT stalls, then issues with md_start in the cycle md_busy falls.
- Reset asserted mid-MD_BUSY clears state, md_cnt and md_busy asynchronously. No md_start is issued on release.
- ex_branch_taken coincident with load_use or md_hold: the flush wins and no stall is counted.

## Test plan
- Reset, then idle: all outputs at reset values. After release, pc_write=1 and if_id_write=1.
- Load-use: id_ex_mem_read=1, id_ex_rt=5, id_rs=5 for one cycle → one cycle with pc_write=0 and id_ex_bubble=1, and stall_cycles=1. Repeat with id_ex_rt=0 → no stall. Repeat with rt match and id_uses_rt=0 → no stall.
- MD issue with MD_LATENCY=8: id_is_md=1 → md_start pulse of 1 cycle. md_busy is high for 8 cycles. A MFHI held in ID stalls 8 cycles, then advances. stall_cycles=8.
- Branch priority: ex_branch_taken=1 together with load_use=1 → if_id_flush=1, id_ex_bubble=1, pc_write=1, and stall_cycles unchanged. A taken branch during MD_BUSY leaves md_busy duration unchanged.
- Reset mid-operation: assert reset 3 cycles into MD_BUSY → md_busy=0 immediately with no clock edge. After release, an MFHI in ID proceeds without stall.
- Saturation: with STALL_CNT_W=4, force 20 stall cycles → stall_cycles holds at 15.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Hazard controller for the 5-stage MIPS pipeline. Handles the cases the
// forwarding unit cannot resolve:
//   * load-use dependences  -> freeze PC and IF/ID, insert one bubble into ID/EX
//   * multi-cycle mult/div  -> issue pulse plus a busy tracker; HI/LO readers
//                              and a second mult/div are held until it finishes
//   * taken branches in EX  -> flush IF/ID and bubble ID/EX
// A saturating counter accumulates stall cycles for performance monitoring.
//
// Ports
//   clk              core clock, rising edge
//   reset            asynchronous, active-high
//   id_rs, id_rt     source register fields of the instruction in ID
//   id_uses_rt       instruction in ID reads rt
//   id_is_md         instruction in ID is MULT/MULTU/DIV/DIVU
//   id_reads_hilo    instruction in ID is MFHI/MFLO
//   id_ex_mem_read   instruction in EX is a load
//   id_ex_rt         destination register of the load in EX
//   ex_branch_taken  branch/jump in EX resolved taken
//   pc_write         PC update enable                    (combinational)
//   if_id_write      IF/ID register enable               (combinational)
//   id_ex_bubble     zero control bits entering ID/EX    (combinational)
//   if_id_flush      clear IF/ID                         (combinational)
//   md_start         one-cycle issue pulse to mult/div   (combinational)
//   md_busy          mult/div unit in progress           (registered)
//   stall_cycles     saturating stall-cycle counter      (registered)
// ----------------------------------------------------------------------------
module hazard_stall_ctrl #(
    parameter int MD_LATENCY  = 8,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic                   id_uses_rt,
    input  logic                   id_is_md,
    input  logic                   id_reads_hilo,
    input  logic                   id_ex_mem_read,
    input  logic [4:0]             id_ex_rt,
    input  logic                   ex_branch_taken,
    output logic                   pc_write,
    output logic                   if_id_write,
    output logic                   id_ex_bubble,
    output logic                   if_id_flush,
    output logic                   md_start,
    output logic                   md_busy,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam int CNT_W = $clog2(MD_LATENCY + 1);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State registers and their next-state values
    // ------------------------------------------------------------------------
    state_t                 state_q,   state_d;
    logic [CNT_W-1:0]       md_cnt_q,  md_cnt_d;
    logic                   md_busy_q, md_busy_d;
    logic [STALL_CNT_W-1:0] stall_q,   stall_d;

    // ------------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------------
    logic rs_match;
    logic rt_match;
    logic load_use;
    logic md_hold;
    logic stall_event;

    // Register $zero is never a real producer, so a load targeting it cannot
    // create a dependence.
    assign rs_match = (id_ex_rt == id_rs);
    assign rt_match = id_uses_rt && (id_ex_rt == id_rt);
    assign load_use = id_ex_mem_read && (id_ex_rt != 5'd0) && (rs_match || rt_match);

    // A second mult/div or a HI/LO read must wait for the op in flight.
    assign md_hold  = md_busy_q && (id_is_md || id_reads_hilo);

    // ------------------------------------------------------------------------
    // Pipeline control (Mealy): priority branch > load-use > md_hold > issue
    // ------------------------------------------------------------------------
    always_comb begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        md_start     = 1'b0;
        stall_event  = 1'b0;

        if (reset) begin
            // Everything held low while the core is in reset.
        end else if (ex_branch_taken) begin
            // The flush already discards the ID instruction, so any stall it
            // would have needed is moot and is not counted.
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            id_ex_bubble = 1'b1;
            if_id_flush  = 1'b1;
        end else if (load_use || md_hold) begin
            id_ex_bubble = 1'b1;
            stall_event  = 1'b1;
        end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            md_start    = id_is_md && !md_busy_q;
        end
    end

    // ------------------------------------------------------------------------
    // Mult/div tracker next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        md_cnt_d  = md_cnt_q;
        md_busy_d = md_busy_q;

        case (state_q)
            RUN: begin
                if (md_start) begin
                    state_d   = MD_BUSY;
                    md_cnt_d  = CNT_W'(MD_LATENCY);
                    md_busy_d = 1'b1;
                end
            end
            MD_BUSY: begin
                // A taken branch does not cancel the count: the issued op is
                // older than the branch and must complete.
                if (md_cnt_q == CNT_W'(1)) begin
                    state_d   = RUN;
                    md_cnt_d  = '0;
                    md_busy_d = 1'b0;
                end else begin
                    md_cnt_d  = md_cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d   = RUN;
                md_cnt_d  = '0;
                md_busy_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Stall counter next state: saturates at all-ones instead of wrapping
    // ------------------------------------------------------------------------
    always_comb begin
        stall_d = stall_q;
        if (stall_event && (stall_q != {STALL_CNT_W{1'b1}})) begin
            stall_d = stall_q + STALL_CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RUN;
            md_cnt_q  <= '0;
            md_busy_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            md_cnt_q  <= md_cnt_d;
            md_busy_q <= md_busy_d;
            stall_q   <= stall_d;
        end
    end

    assign md_busy      = md_busy_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

    // ------------------------------------------------------------------------
    // Main DUT (MD_LATENCY=8, STALL_CNT_W=16)
    // ------------------------------------------------------------------------
    logic        clk;
    logic        reset;
    logic [4:0]  id_rs, id_rt, id_ex_rt;
    logic        id_uses_rt, id_is_md, id_reads_hilo, id_ex_mem_read, ex_branch_taken;
    logic        pc_write, if_id_write, id_ex_bubble, if_id_flush, md_start, md_busy;
    logic [15:0] stall_cycles;

    hazard_stall_ctrl #(.MD_LATENCY(8), .STALL_CNT_W(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .id_is_md        (id_is_md),
        .id_reads_hilo   (id_reads_hilo),
        .id_ex_mem_read  (id_ex_mem_read),
        .id_ex_rt        (id_ex_rt),
        .ex_branch_taken (ex_branch_taken),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .id_ex_bubble    (id_ex_bubble),
        .if_id_flush     (if_id_flush),
        .md_start        (md_start),
        .md_busy         (md_busy),
        .stall_cycles    (stall_cycles)
    );

    // ------------------------------------------------------------------------
    // Saturation DUT (STALL_CNT_W=4), held in a permanent load-use
    // ------------------------------------------------------------------------
    logic       s_reset;
    logic [4:0] s_rs, s_rt, s_ex_rt;
    logic       s_uses_rt, s_is_md, s_reads_hilo, s_mem_read, s_branch;
    logic       s_pc_write, s_if_id_write, s_bubble, s_flush, s_md_start, s_md_busy;
    logic [3:0] s_stall;

    hazard_stall_ctrl #(.MD_LATENCY(2), .STALL_CNT_W(4)) dut_sat (
        .clk             (clk),
        .reset           (s_reset),
        .id_rs           (s_rs),
        .id_rt           (s_rt),
        .id_uses_rt      (s_uses_rt),
        .id_is_md        (s_is_md),
        .id_reads_hilo   (s_reads_hilo),
        .id_ex_mem_read  (s_mem_read),
        .id_ex_rt        (s_ex_rt),
        .ex_branch_taken (s_branch),
        .pc_write        (s_pc_write),
        .if_id_write     (s_if_id_write),
        .id_ex_bubble    (s_bubble),
        .if_id_flush     (s_flush),
        .md_start        (s_md_start),
        .md_busy         (s_md_busy),
        .stall_cycles    (s_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------------
    typedef struct {
        string       tag;
        logic [31:0] val;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int n_cmp = 0;
    int n_mis = 0;
    int exp_stall = 0;

    task automatic sb_push(input string tag, input logic [31:0] val);
        sb_entry_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop_cmp(input logic [31:0] obs);
        sb_entry_t e;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_mis++;
            $error("FAIL scoreboard_empty: observed %0h required an expected entry", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val)
            else begin
                n_mis++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    // One pipeline cycle: expectations pushed as the stimulus is applied,
    // DUT sampled at the falling edge, then advance past the rising edge.
    task automatic cycle(input string tag,
                         input logic e_pc, input logic e_ifid, input logic e_bub,
                         input logic e_flush, input logic e_start, input logic e_busy,
                         input int e_stall);
        sb_push({tag, ".pc_write"},     32'(e_pc));
        sb_push({tag, ".if_id_write"},  32'(e_ifid));
        sb_push({tag, ".id_ex_bubble"}, 32'(e_bub));
        sb_push({tag, ".if_id_flush"},  32'(e_flush));
        sb_push({tag, ".md_start"},     32'(e_start));
        sb_push({tag, ".md_busy"},      32'(e_busy));
        sb_push({tag, ".stall_cycles"}, 32'(e_stall));
        @(negedge clk);
        sb_pop_cmp(32'(pc_write));
        sb_pop_cmp(32'(if_id_write));
        sb_pop_cmp(32'(id_ex_bubble));
        sb_pop_cmp(32'(if_id_flush));
        sb_pop_cmp(32'(md_start));
        sb_pop_cmp(32'(md_busy));
        sb_pop_cmp(32'(stall_cycles));
        $display("[%0t] %s pc=%b ifid=%b bub=%b flush=%b start=%b busy=%b stalls=%0d",
                 $time, tag, pc_write, if_id_write, id_ex_bubble, if_id_flush,
                 md_start, md_busy, stall_cycles);
        @(posedge clk);
        #1;
    endtask

    task automatic check_now(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        sb_push(tag, exp_v);
        sb_pop_cmp(obs);
        $display("[%0t] %s value=%0d", $time, tag, obs);
    endtask

    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_ex_rt = 5'd0;
        id_uses_rt = 1'b0; id_is_md = 1'b0; id_reads_hilo = 1'b0;
        id_ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        reset = 1'b1;
        clear_inputs();
        s_reset = 1'b1;
        s_rs = 5'd5; s_rt = 5'd0; s_ex_rt = 5'd5; s_uses_rt = 1'b0;
        s_is_md = 1'b0; s_reads_hilo = 1'b0; s_mem_read = 1'b1; s_branch = 1'b0;

        @(posedge clk); @(posedge clk); #1;

        // Reset held: all outputs low
        cycle("reset_hold", 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        cycle("idle", 1, 1, 0, 0, 0, 0, exp_stall);

        // Load-use on rs: one bubble
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd5; id_rs = 5'd5;
        cycle("load_use_rs", 0, 0, 1, 0, 0, 0, exp_stall);
        exp_stall++;
        clear_inputs();
        cycle("load_use_after", 1, 1, 0, 0, 0, 0, exp_stall);

        // Load to $zero never stalls
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd0; id_rs = 5'd0;
        cycle("load_rt_zero", 1, 1, 0, 0, 0, 0, exp_stall);

        // rt match but rt not a source
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b0;
        cycle("rt_unused", 1, 1, 0, 0, 0, 0, exp_stall);
        id_uses_rt = 1'b1;
        cycle("load_use_rt", 0, 0, 1, 0, 0, 0, exp_stall);
        exp_stall++;
        clear_inputs();
        cycle("rt_after", 1, 1, 0, 0, 0, 0, exp_stall);

        // MULT issue followed by MFHI held for the full latency
        id_is_md = 1'b1;
        cycle("mult_issue", 1, 1, 0, 0, 1, 0, exp_stall);
        id_is_md = 1'b0; id_reads_hilo = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle("mfhi_hold", 0, 0, 1, 0, 0, 1, exp_stall);
            exp_stall++;
        end
        cycle("mfhi_go", 1, 1, 0, 0, 0, 0, exp_stall);
        clear_inputs();

        // Back-to-back MULT: second stalls, then issues as busy falls
        id_is_md = 1'b1;
        cycle("mult1_issue", 1, 1, 0, 0, 1, 0, exp_stall);
        for (int k = 0; k < 8; k++) begin
            cycle("mult2_hold", 0, 0, 1, 0, 0, 1, exp_stall);
            exp_stall++;
        end
        cycle("mult2_issue", 1, 1, 0, 0, 1, 0, exp_stall);
        id_is_md = 1'b0;

        // During busy: independent instructions flow, branches flush without
        // shortening the count, branch beats md_hold without counting a stall
        for (int k = 0; k < 8; k++) begin
            ex_branch_taken = (k == 2 || k == 4);
            id_reads_hilo   = (k == 4);
            if (k == 2 || k == 4)
                cycle("busy_branch", 1, 1, 1, 1, 0, 1, exp_stall);
            else
                cycle("busy_free", 1, 1, 0, 0, 0, 1, exp_stall);
        end
        clear_inputs();
        cycle("mult2_done", 1, 1, 0, 0, 0, 0, exp_stall);

        // Branch together with load-use: flush wins, stall not counted
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd9; id_rs = 5'd9; ex_branch_taken = 1'b1;
        cycle("branch_vs_load_use", 1, 1, 1, 1, 0, 0, exp_stall);
        clear_inputs();
        cycle("branch_after", 1, 1, 0, 0, 0, 0, exp_stall);

        // Reset three cycles into MD_BUSY
        id_is_md = 1'b1;
        cycle("mult3_issue", 1, 1, 0, 0, 1, 0, exp_stall);
        id_is_md = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle("mult3_busy", 1, 1, 0, 0, 0, 1, exp_stall);
        end
        check_now("busy_before_reset", 32'(md_busy), 32'd1);
        reset = 1'b1;
        id_is_md = 1'b1;
        #1;
        exp_stall = 0;
        check_now("async_reset_md_busy", 32'(md_busy), 32'd0);
        check_now("async_reset_stall_cycles", 32'(stall_cycles), 32'(exp_stall));
        check_now("async_reset_md_start", 32'(md_start), 32'd0);
        check_now("async_reset_pc_write", 32'(pc_write), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        id_is_md = 1'b0; id_reads_hilo = 1'b1;
        cycle("post_reset_mfhi", 1, 1, 0, 0, 0, 0, exp_stall);
        clear_inputs();

        // Saturation on the 4-bit counter
        s_reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_now("sat_after_10", 32'(s_stall), 32'd10);
        repeat (10) @(posedge clk);
        #1;
        check_now("sat_after_20", 32'(s_stall), 32'd15);
        repeat (5) @(posedge clk);
        #1;
        check_now("sat_after_25", 32'(s_stall), 32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    // Global time bound so the bench can never hang
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule
